pix_colour_pipe: RTL

Parametrised pixel-output colour pipeline. It sits between the palette lookup and the display outputs. Per pixel clock it converts a YCoCg palette entry to clamped RGB at configurable component widths. It delays the sync/coordinate sideband by exactly the same latency, and it applies a frame-latched output mode so mode changes never tear mid-frame.

---
 rtl/vdp_pkg.sv | 22 ++
 rtl/pix_clamp_scale.sv | 66 ++++++
 rtl/pix_colour_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// Shared video-pipeline types: pixel output modes, colour pipe latency, 2x2 ordered dither table.
// Pure definitions, no logic.
// No flow control.
package vdp_pkg;

    typedef enum logic [1:0] {
        PIX_YCOCG = 2'd0,
        PIX_GREY  = 2'd1,
        PIX_BLANK = 2'd2,
        PIX_RSVD  = 2'd3
    } pix_mode_t;

    localparam int PIX_COLOUR_LAT = 5;

    // Indexed by {sy[0], sx[0]}: 0,2,3,1 in quarters of the dropped-LSB range
    localparam logic [7:0] PIX_DITHER_TBL = {2'd1, 2'd3, 2'd2, 2'd0};

    function automatic logic [1:0] pix_dither(input logic [1:0] idx);
        return PIX_DITHER_TBL[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/pix_clamp_scale.sv
// Saturates a signed channel to [0, 2^YW-1] and rescales it to OUTW bits (replicate / pass / truncate or dither).
// Combinational, zero latency; the caller registers the result.
// No flow control. Dither uses PIX_COLOUR_PIPE_DITHER_EN.
module pix_clamp_scale
    import vdp_pkg::*;
#(
    parameter int IW   = 10,
    parameter int YW   = 7,
    parameter int OUTW = 8
) (
    input  logic signed [IW-1:0] val,
    input  logic                 sx0,
    input  logic                 sy0,
    output logic [OUTW-1:0]      q
);

    localparam logic signed [IW-1:0] VMAX = IW'((1 << YW) - 1);

    logic [YW-1:0] cl;

    always_comb begin
        if (val[IW-1])
            cl = '0;
        else if (val > VMAX)
            cl = '1;
        else
            cl = val[YW-1:0];
    end

    generate
        if (OUTW > YW) begin : g_rep
            logic unused_pos;
            assign unused_pos = sx0 ^ sy0;
            // Repeat the MSBs into the vacated LSBs so full scale maps to all-ones
            always_comb begin
                q = '0;
                for (int i = 0; i < OUTW; i++)
                    q[OUTW-1-i] = cl[YW-1-(i%YW)];
            end
        end else if (OUTW == YW) begin : g_pass
            logic unused_pos;
            assign unused_pos = sx0 ^ sy0;
            assign q = cl;
        end else begin : g_trunc
`ifdef PIX_COLOUR_PIPE_DITHER_EN
            localparam int D = YW - OUTW;
            logic [YW+2:0] off;
            logic [YW:0]   sum;
            logic [YW-1:0] sat;
            logic          unused_lsb;
            always_comb begin
                off = ({{(YW+1){1'b0}}, pix_dither({sy0, sx0})} << D) >> 2;
                sum = {1'b0, cl} + off[YW:0];
                sat = sum[YW] ? '1 : sum[YW-1:0];
            end
            assign q          = sat[YW-1 -: OUTW];
            assign unused_lsb = ^{off[YW+2:YW+1], sat[D-1:0]};
`else
            logic unused_lsb;
            assign q          = cl[YW-1 -: OUTW];
            assign unused_lsb = ^{cl[YW-OUTW-1:0], sx0, sy0};
`endif
        end
    endgenerate

endmodule

// File: rtl/pix_colour_pipe.sv
// YCoCg -> clamped RGB pixel output pipe with frame-latched mode; optional dither via PIX_COLOUR_PIPE_DITHER_EN.
// Latency: 5 clk_pix for data and sideband alike.
// No backpressure: one pixel accepted every cycle.
module pix_colour_pipe
    import vdp_pkg::*;
#(
    parameter int CORDW = 11,
    parameter int YW    = 7,
    parameter int CW    = 8,
    parameter int OUTW  = 8
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             frame_i,
    input  logic [1:0]       mode_i,
    input  logic [YW-1:0]    y_i,
    input  logic [CW-1:0]    co_i,
    input  logic [CW-1:0]    cg_i,
    input  logic [CORDW-1:0] sx_i,
    input  logic [CORDW-1:0] sy_i,
    input  logic             de_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [OUTW-1:0]  r,
    output logic [OUTW-1:0]  g,
    output logic [OUTW-1:0]  b,
    output logic [1:0]       mode_o
);

    localparam int IW = CW + 2;
    localparam int L  = PIX_COLOUR_LAT;

    pix_mode_t mode_q, mode_in;

    // The frame-start pixel already uses the newly requested mode
    assign mode_in = frame_i ? pix_mode_t'(mode_i) : mode_q;
    assign mode_o  = mode_q;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix)
            mode_q <= PIX_YCOCG;
        else if (frame_i)
            mode_q <= pix_mode_t'(mode_i);
    end

    logic [CORDW-1:0] sx_d [L];
    logic [CORDW-1:0] sy_d [L];
    logic             de_d [L];
    logic             hs_d [L];
    logic             vs_d [L];

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < L; i++) begin
                sx_d[i] <= '0;
                sy_d[i] <= '0;
                de_d[i] <= 1'b0;
                hs_d[i] <= 1'b0;
                vs_d[i] <= 1'b0;
            end
        end else begin
            sx_d[0] <= sx_i;
            sy_d[0] <= sy_i;
            de_d[0] <= de_i;
            hs_d[0] <= hsync_i;
            vs_d[0] <= vsync_i;
            for (int i = 1; i < L; i++) begin
                sx_d[i] <= sx_d[i-1];
                sy_d[i] <= sy_d[i-1];
                de_d[i] <= de_d[i-1];
                hs_d[i] <= hs_d[i-1];
                vs_d[i] <= vs_d[i-1];
            end
        end
    end

    assign sx    = sx_d[L-1];
    assign sy    = sy_d[L-1];
    assign de    = de_d[L-1];
    assign hsync = hs_d[L-1];
    assign vsync = vs_d[L-1];

    logic signed [IW-1:0] y_x, co_x, cg_x;
    assign y_x  = IW'(y_i);
    assign co_x = IW'($signed(co_i));
    assign cg_x = IW'($signed(cg_i));

    logic signed [IW-1:0] tmp1, co1, cg1, g2, b2, co2, r3, g3, b3;
    logic [YW-1:0]        y1, y2;
    logic [OUTW-1:0]      r4, g4, b4, r4_c, g4_c, b4_c;
    pix_mode_t            m1, m2, m3, m4;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            tmp1 <= '0; co1 <= '0; cg1 <= '0; y1 <= '0; m1 <= PIX_YCOCG;
            g2   <= '0; b2  <= '0; co2 <= '0; y2 <= '0; m2 <= PIX_YCOCG;
            r3   <= '0; g3  <= '0; b3  <= '0;           m3 <= PIX_YCOCG;
            r4   <= '0; g4  <= '0; b4  <= '0;           m4 <= PIX_YCOCG;
            r    <= '0; g   <= '0; b   <= '0;
        end else begin
            tmp1 <= y_x - (cg_x >>> 1);
            co1  <= co_x;
            cg1  <= cg_x;
            y1   <= y_i;
            m1   <= mode_in;

            g2   <= cg1 + tmp1;
            b2   <= tmp1 - (co1 >>> 1);
            co2  <= co1;
            y2   <= y1;
            m2   <= m1;

            // Grey mode bypasses the conversion result with luma on all channels
            if (m2 == PIX_GREY) begin
                r3 <= IW'(y2);
                g3 <= IW'(y2);
                b3 <= IW'(y2);
            end else begin
                r3 <= b2 + co2;
                g3 <= g2;
                b3 <= b2;
            end
            m3 <= m2;

            r4 <= r4_c;
            g4 <= g4_c;
            b4 <= b4_c;
            m4 <= m3;

            if (de_d[3] && (m4 == PIX_YCOCG || m4 == PIX_GREY)) begin
                r <= r4;
                g <= g4;
                b <= b4;
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end
    end

    pix_clamp_scale #(.IW(IW), .YW(YW), .OUTW(OUTW)) u_cs_r (
        .val(r3), .sx0(sx_d[2][0]), .sy0(sy_d[2][0]), .q(r4_c)
    );
    pix_clamp_scale #(.IW(IW), .YW(YW), .OUTW(OUTW)) u_cs_g (
        .val(g3), .sx0(sx_d[2][0]), .sy0(sy_d[2][0]), .q(g4_c)
    );
    pix_clamp_scale #(.IW(IW), .YW(YW), .OUTW(OUTW)) u_cs_b (
        .val(b3), .sx0(sx_d[2][0]), .sy0(sy_d[2][0]), .q(b4_c)
    );

endmodule
